// File: rtl/return_addr_stack.sv
// Return address stack for the fetch-stage branch predictor.
// A call pushes its link address (pc + 2 or pc + 4). A return pops the stack
// and supplies the predicted target to the next-PC mux in the same cycle.
// The storage is a circular buffer, so a push into a full stack overwrites
// the oldest entry.
//
// Optional feature: define RAS_CHECKPOINT_EN to add ckpt_save_i. A flush then
// restores a saved {tos_ptr, count} snapshot instead of emptying the stack.
//
// Handshake: there is no backpressure. A call or return is accepted in every
// cycle where valid_i = 1 and flush_i = 0. pred_valid_o is a qualifier, not a
// handshake. It is high only while a return is being accepted and the stack
// is non-empty.
module return_addr_stack #(
    parameter  int DEPTH = 8,
    parameter  int XLEN  = 32,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic             is_compressed_i,
    input  logic             call_i,
    input  logic             return_i,
    input  logic             flush_i,
`ifdef RAS_CHECKPOINT_EN
    input  logic             ckpt_save_i,
`endif
    output logic             pred_valid_o,
    output logic [XLEN-1:0]  pred_target_o,
    output logic [PTR_W:0]   count_o,
    output logic             overflow_o
);

    localparam logic [PTR_W-1:0] TOS_RST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   FULL    = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] tos_q, tos_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [XLEN-1:0]  entries_q [DEPTH];
    logic [XLEN-1:0]  entries_d [DEPTH];

    logic             do_push;
    logic             do_pop;
    logic [XLEN-1:0]  link;
    logic [PTR_W-1:0] tos_inc;
    logic [PTR_W-1:0] tos_dec;

`ifdef RAS_CHECKPOINT_EN
    logic [PTR_W-1:0] snap_tos_q, snap_tos_d;
    logic [PTR_W:0]   snap_count_q, snap_count_d;
`endif

    // A flush drops any call or return seen in the same cycle.
    always_comb begin
        do_push = valid_i & call_i & ~flush_i;
        do_pop  = valid_i & return_i & ~flush_i;
        link    = pc_i + (is_compressed_i ? XLEN'(2) : XLEN'(4));
        tos_inc = tos_q + PTR_W'(1);
        tos_dec = tos_q - PTR_W'(1);
    end

    // The top of stack is always visible, so the next-PC mux may sample it speculatively.
    always_comb begin
        pred_target_o = entries_q[tos_q];
        pred_valid_o  = do_pop & (count_q != '0);
        count_o       = count_q;
        overflow_o    = overflow_q;
    end

    // Next-state logic for pointer, count, entries and the overflow pulse.
    always_comb begin
        tos_d      = tos_q;
        count_d    = count_q;
        overflow_d = 1'b0;
        entries_d  = entries_q;
`ifdef RAS_CHECKPOINT_EN
        snap_tos_d   = snap_tos_q;
        snap_count_d = snap_count_q;
`endif
        if (flush_i) begin
`ifdef RAS_CHECKPOINT_EN
            tos_d   = snap_tos_q;
            count_d = snap_count_q;
`else
            tos_d   = TOS_RST;
            count_d = '0;
`endif
        end else if (do_push && do_pop) begin
            // A call and a return together (e.g. jalr x1,0(x1)) replace the top in place.
            if (count_q == '0) begin
                tos_d              = tos_inc;
                count_d            = (PTR_W + 1)'(1);
                entries_d[tos_inc] = link;
            end else begin
                entries_d[tos_q] = link;
            end
        end else if (do_push) begin
            tos_d              = tos_inc;
            entries_d[tos_inc] = link;
            if (count_q == FULL) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + (PTR_W + 1)'(1);
            end
        end else if (do_pop) begin
            if (count_q != '0) begin
                tos_d   = tos_dec;
                count_d = count_q - (PTR_W + 1)'(1);
            end
        end
`ifdef RAS_CHECKPOINT_EN
        // The snapshot takes the state after this cycle's push or pop. A restore wins over a save.
        if (ckpt_save_i && !flush_i) begin
            snap_tos_d   = tos_d;
            snap_count_d = count_d;
        end
`endif
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tos_q      <= TOS_RST;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            tos_q      <= tos_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

`ifdef RAS_CHECKPOINT_EN
    // Checkpoint registers; reset to the empty-stack state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_tos_q   <= TOS_RST;
            snap_count_q <= '0;
        end else begin
            snap_tos_q   <= snap_tos_d;
            snap_count_q <= snap_count_d;
        end
    end
`endif

endmodule
